adsr_envelope_generator: RTL and testbench

- Parametrised successor to the single-slope envelope follower. Full attack/decay/sustain/release (ADSR) envelope with per-stage rates and a programmable sustain level.
- Scales the incoming oscillator sample by the envelope level.
- Sits between the oscillator and the output mixer. Advances one step per sample strobe, synchronous to the system clock.

---
 rtl/adsr_envelope_generator_pkg.sv | 16 +
 rtl/adsr_envelope_generator_if.sv | 36 +++
 rtl/adsr_envelope_generator_envelope_step.sv | 78 +++++++
 rtl/adsr_envelope_generator.sv | 110 +++++++++++
 tb/tb_adsr_envelope_generator.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/adsr_envelope_generator_pkg.sv
// Shared definitions for the ADSR envelope generator: state encoding and default widths.
// Optional build macro used elsewhere: ADSR_VELOCITY_PEAK_EN.
package adsr_envelope_generator_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 12;
    localparam int unsigned DEFAULT_RATE_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

endpackage

// File: rtl/adsr_envelope_generator_if.sv
// Sample/control bundle between the oscillator side and the envelope generator.
// inVelocity is only consumed when ADSR_VELOCITY_PEAK_EN is defined.
interface adsr_envelope_generator_if
    import adsr_envelope_generator_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned RATE_WIDTH = DEFAULT_RATE_WIDTH
) ();

    logic                  inSampleReady;
    logic [WIDTH-1:0]      inSample;
    logic                  inIsPlaying;
    logic [RATE_WIDTH-1:0] inAttackRate;
    logic [RATE_WIDTH-1:0] inDecayRate;
    logic [WIDTH-1:0]      inSustain;
    logic [RATE_WIDTH-1:0] inReleaseRate;
    logic [WIDTH-1:0]      inVelocity;
    logic [WIDTH-1:0]      outSample;
    logic                  outSampleReady;
    logic [WIDTH-1:0]      outLevel;
    logic [2:0]            outState;
    logic                  outBusy;

    modport master (
        output inSampleReady, inSample, inIsPlaying, inAttackRate, inDecayRate,
               inSustain, inReleaseRate, inVelocity,
        input  outSample, outSampleReady, outLevel, outState, outBusy
    );

    modport slave (
        input  inSampleReady, inSample, inIsPlaying, inAttackRate, inDecayRate,
               inSustain, inReleaseRate, inVelocity,
        output outSample, outSampleReady, outLevel, outState, outBusy
    );

endinterface

// File: rtl/adsr_envelope_generator_envelope_step.sv
// Combinational ADSR step: next level and next state for one sample strobe.
// All arithmetic is WIDTH+1 bits so carry and borrow appear in the top bit.
module adsr_envelope_generator_envelope_step
    import adsr_envelope_generator_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned RATE_WIDTH = DEFAULT_RATE_WIDTH
) (
    input  logic                  gate,
    input  state_t                state,
    input  logic [WIDTH-1:0]      level,
    input  logic [RATE_WIDTH-1:0] attack_rate,
    input  logic [RATE_WIDTH-1:0] decay_rate,
    input  logic [RATE_WIDTH-1:0] release_rate,
    input  logic [WIDTH-1:0]      sust_eff,
    input  logic [WIDTH-1:0]      peak,
    output logic [WIDTH-1:0]      level_next,
    output state_t                state_next
);

    localparam int unsigned EXT_W = WIDTH + 1;

    logic [WIDTH:0] att_sum;
    logic [WIDTH:0] dec_diff;
    logic [WIDTH:0] rel_diff;

    always_comb begin
        att_sum  = {1'b0, level} + EXT_W'(attack_rate);
        dec_diff = {1'b0, level} - EXT_W'(decay_rate);
        rel_diff = {1'b0, level} - EXT_W'(release_rate);
    end

    always_comb begin
        level_next = level;
        state_next = state;
        // Gate transitions win over stage arithmetic and leave the level untouched.
        if (!gate && (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN)) begin
            state_next = ST_RELEASE;
        end else if (gate && (state == ST_IDLE || state == ST_RELEASE)) begin
            state_next = ST_ATTACK;
        end else begin
            case (state)
                ST_ATTACK: begin
                    if (att_sum >= {1'b0, peak}) begin
                        level_next = peak;
                        state_next = ST_DECAY;
                    end else begin
                        level_next = att_sum[WIDTH-1:0];
                    end
                end
                ST_DECAY: begin
                    if (dec_diff[WIDTH] || dec_diff[WIDTH-1:0] <= sust_eff) begin
                        level_next = sust_eff;
                        state_next = ST_SUSTAIN;
                    end else begin
                        level_next = dec_diff[WIDTH-1:0];
                    end
                end
                ST_SUSTAIN: begin
                    level_next = sust_eff;
                end
                ST_RELEASE: begin
                    if (rel_diff[WIDTH] || rel_diff[WIDTH-1:0] == '0) begin
                        level_next = '0;
                        state_next = ST_IDLE;
                    end else begin
                        level_next = rel_diff[WIDTH-1:0];
                    end
                end
                default: begin
                    level_next = '0;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/adsr_envelope_generator.sv
// ADSR envelope generator: steps the envelope on each sample strobe and scales the sample.
// Define ADSR_VELOCITY_PEAK_EN to take the attack peak from inVelocity latched at note-on.
module adsr_envelope_generator
    import adsr_envelope_generator_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned RATE_WIDTH = DEFAULT_RATE_WIDTH
) (
    input  logic                       inClk,
    input  logic                       inResetN,
    adsr_envelope_generator_if.slave   bus
);

    localparam int unsigned PW = 2 * WIDTH;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] out_sample_q, out_sample_d;
    logic             out_ready_q, out_ready_d;

    state_t           step_state;
    logic [WIDTH-1:0] step_level;
    logic [WIDTH-1:0] peak;
    logic [WIDTH-1:0] sust_eff;
    logic [PW-1:0]    product;

`ifdef ADSR_VELOCITY_PEAK_EN
    logic [WIDTH-1:0] velocity_q, velocity_d;

    always_comb begin
        peak = (velocity_q == '0) ? WIDTH'(1) : velocity_q;
        velocity_d = velocity_q;
        // Latch velocity only on the strobe that enters ATTACK from IDLE/RELEASE.
        if (bus.inSampleReady && step_state == ST_ATTACK && state_q != ST_ATTACK) begin
            velocity_d = bus.inVelocity;
        end
    end

    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            velocity_q <= '1;
        end else begin
            velocity_q <= velocity_d;
        end
    end
`else
    logic unused_velocity;

    always_comb begin
        peak = '1;
    end

    assign unused_velocity = ^bus.inVelocity;
`endif

    always_comb begin
        sust_eff = (bus.inSustain < peak) ? bus.inSustain : peak;
    end

    adsr_envelope_generator_envelope_step #(
        .WIDTH      (WIDTH),
        .RATE_WIDTH (RATE_WIDTH)
    ) u_envelope_step (
        .gate         (bus.inIsPlaying),
        .state        (state_q),
        .level        (level_q),
        .attack_rate  (bus.inAttackRate),
        .decay_rate   (bus.inDecayRate),
        .release_rate (bus.inReleaseRate),
        .sust_eff     (sust_eff),
        .peak         (peak),
        .level_next   (step_level),
        .state_next   (step_state)
    );

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        out_sample_d = out_sample_q;
        out_ready_d  = 1'b0;
        product      = PW'(bus.inSample) * PW'(step_level);
        if (bus.inSampleReady) begin
            state_d      = step_state;
            level_d      = step_level;
            out_sample_d = WIDTH'(product >> WIDTH);
            out_ready_d  = 1'b1;
        end
    end

    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            state_q      <= ST_IDLE;
            level_q      <= '0;
            out_sample_q <= '0;
            out_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            out_sample_q <= out_sample_d;
            out_ready_q  <= out_ready_d;
        end
    end

    assign bus.outSample      = out_sample_q;
    assign bus.outSampleReady = out_ready_q;
    assign bus.outLevel       = level_q;
    assign bus.outState       = state_q;
    assign bus.outBusy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope_generator.sv
// Scoreboard bench for adsr_envelope_generator: directed strobes push expected results,
// a negedge monitor pops and compares on every outSampleReady pulse.
module tb_adsr_envelope_generator;
    import adsr_envelope_generator_pkg::*;

    localparam int unsigned W  = 12;
    localparam int unsigned RW = 12;

    typedef struct {
        logic [W-1:0] level;
        logic [2:0]   state;
        logic [W-1:0] sample;
        string        tag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    exp_t        sb_q[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic        prev_ready = 1'b0;

    always #5 clk = ~clk;

    adsr_envelope_generator_if #(.WIDTH(W), .RATE_WIDTH(RW)) bus ();

    adsr_envelope_generator #(.WIDTH(W), .RATE_WIDTH(RW)) dut (
        .inClk    (clk),
        .inResetN (rst_n),
        .bus      (bus)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    task automatic strobe(input logic [W-1:0] lvl, input logic [2:0] st,
                          input logic [W-1:0] smp, input string tag);
        exp_t e;
        e.level  = lvl;
        e.state  = st;
        e.sample = smp;
        e.tag    = tag;
        sb_q.push_back(e);
        @(negedge clk);
        bus.inSampleReady = 1'b1;
        @(negedge clk);
        bus.inSampleReady = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_regs(input string tag, input logic [W-1:0] lvl, input logic [2:0] st,
                              input logic [W-1:0] smp, input logic rdy, input logic busy);
        check({tag, "_level"},  32'(bus.outLevel),       32'(lvl));
        check({tag, "_state"},  32'(bus.outState),       32'(st));
        check({tag, "_sample"}, 32'(bus.outSample),      32'(smp));
        check({tag, "_ready"},  32'(bus.outSampleReady), 32'(rdy));
        check({tag, "_busy"},   32'(bus.outBusy),        32'(busy));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.outSampleReady) begin
            check("ready_single_cycle", 32'(prev_ready), 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output sample=%0d level=%0d expected=no_pulse",
                         bus.outSample, bus.outLevel);
            end else begin
                e = sb_q.pop_front();
                check({e.tag, "_level"},  32'(bus.outLevel),  32'(e.level));
                check({e.tag, "_state"},  32'(bus.outState),  32'(e.state));
                check({e.tag, "_sample"}, 32'(bus.outSample), 32'(e.sample));
            end
        end
        prev_ready = rst_n && bus.outSampleReady;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.inSampleReady = 1'b0;
        bus.inSample      = 12'd4095;
        bus.inIsPlaying   = 1'b0;
        bus.inAttackRate  = 12'd1024;
        bus.inDecayRate   = 12'd0;
        bus.inSustain     = 12'd3000;
        bus.inReleaseRate = 12'd64;
        bus.inVelocity    = 12'd4095;

        repeat (3) @(negedge clk);
        check_regs("reset", 12'd0, 3'd0, 12'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // With inSample=4095 the scaled output is level-1 for any nonzero level.
        bus.inIsPlaying = 1'b1;
        strobe(12'd0,    3'd1, 12'd0,    "att_enter");
        strobe(12'd1024, 3'd1, 12'd1023, "att1");
        strobe(12'd2048, 3'd1, 12'd2047, "att2");
        strobe(12'd3072, 3'd1, 12'd3071, "att3");
        strobe(12'd4095, 3'd2, 12'd4094, "att_peak");
        strobe(12'd4095, 3'd2, 12'd4094, "decay_rate0_hold");

        bus.inDecayRate = 12'd300;
        strobe(12'd3795, 3'd2, 12'd3794, "dec1");
        strobe(12'd3495, 3'd2, 12'd3494, "dec2");
        strobe(12'd3195, 3'd2, 12'd3194, "dec3");
        strobe(12'd3000, 3'd3, 12'd2999, "dec_floor");
        bus.inSustain = 12'd2000;
        strobe(12'd2000, 3'd3, 12'd1999, "sust_track");

        bus.inSample  = 12'd4000;
        bus.inSustain = 12'd2048;
        strobe(12'd2048, 3'd3, 12'd2000, "scale_2048");
        bus.inSustain = 12'd2047;
        strobe(12'd2047, 3'd3, 12'd1999, "scale_2047");

        bus.inSustain   = 12'd100;
        bus.inIsPlaying = 1'b0;
        bus.inSample    = 12'd1;
        repeat (3) @(negedge clk);
        check_regs("no_strobe_hold", 12'd2047, 3'd3, 12'd1999, 1'b0, 1'b1);
        bus.inIsPlaying = 1'b1;
        bus.inSample    = 12'd4095;
        strobe(12'd100, 3'd3, 12'd99, "sust_100");

        bus.inIsPlaying = 1'b0;
        strobe(12'd100, 3'd4, 12'd99, "rel_enter");
        strobe(12'd36,  3'd4, 12'd35, "rel1");
        check("rel_busy_high", 32'(bus.outBusy), 32'd1);
        strobe(12'd0,   3'd0, 12'd0,  "rel_idle");
        check("rel_busy_low", 32'(bus.outBusy), 32'd0);

        bus.inAttackRate = 12'd500;
        bus.inIsPlaying  = 1'b1;
        strobe(12'd0,   3'd1, 12'd0,   "rt_att_enter");
        strobe(12'd500, 3'd1, 12'd499, "rt_att1");
        bus.inIsPlaying = 1'b0;
        strobe(12'd500, 3'd4, 12'd499, "rt_release");
        bus.inIsPlaying = 1'b1;
        strobe(12'd500,  3'd1, 12'd499, "retrigger");
        strobe(12'd1000, 3'd1, 12'd999, "retrigger_att");

        #2;
        rst_n = 1'b0;
        #1;
        check_regs("reset_mid_attack", 12'd0, 3'd0, 12'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef ADSR_VELOCITY_PEAK_EN
        bus.inVelocity   = 12'd2000;
        bus.inAttackRate = 12'd1500;
        strobe(12'd0,    3'd1, 12'd0,    "vel_enter");
        strobe(12'd1500, 3'd1, 12'd1499, "vel_att1");
        strobe(12'd2000, 3'd2, 12'd1999, "vel_peak");
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
